// File: rtl/lfsr_pkg.sv
// Shared definitions for the 6-bit Galois LFSR link: width, feedback taps,
// generator seed, successor function and the checker state type.
package lfsr_pkg;

  localparam int LFSR_W = 6;
  localparam logic [LFSR_W-1:0] TAP_MASK = 6'b110101;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 6'b111111;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // Galois step: shift up one stage, fold stage 5 back in through the taps.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? TAP_MASK : '0);
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Receive word stream into the checker and its status outputs back out.
// in_valid qualifies in_word for exactly one cycle; there is no back-pressure.
interface lfsr_checker_if #(
  parameter int ERR_W = 16
);
  import lfsr_pkg::*;

  logic              in_valid;
  logic [LFSR_W-1:0] in_word;
  logic              clr_cnt;
  logic              locked;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;
  logic              zero_flag;
  chk_state_t        state;

  modport master (
    output in_valid, in_word, clr_cnt,
    input  locked, err_pulse, err_count, zero_flag, state
  );

  modport slave (
    input  in_valid, in_word, clr_cnt,
    output locked, err_pulse, err_count, zero_flag, state
  );

endinterface

// File: rtl/lfsr_checker.sv
// Sequence checker for the 6-bit Galois LFSR with lock/unlock hysteresis and a
// saturating error counter. Define LFSR_CHK_ZERO_DET_EN to flag all-zero words.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  lfsr_checker_if.slave bus
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  logic [LFSR_W-1:0] prev;
  logic              prev_vld;
  logic [3:0]        match_cnt, match_nxt;
  logic [3:0]        miss_cnt, miss_nxt;
  chk_state_t        state, state_nxt;
  logic              err_pulse, pulse_nxt;
  logic [ERR_W-1:0]  err_count, count_nxt;
  logic              match;

  always_comb begin
    match = (bus.in_word == lfsr_next(prev));
`ifdef LFSR_CHK_ZERO_DET_EN
    if (bus.in_word == '0) match = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    pulse_nxt = 1'b0;
    count_nxt = err_count;
    if (bus.in_valid && prev_vld) begin
      unique case (state)
        HUNT: begin
          if (!match) begin
            match_nxt = '0;
          end else if (match_cnt == LOCK_C - 4'd1) begin
            state_nxt = LOCKED;
            match_nxt = '0;
            miss_nxt  = '0;
          end else begin
            match_nxt = match_cnt + 4'd1;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_nxt = '0;
          end else begin
            pulse_nxt = 1'b1;
            if (!(&err_count)) count_nxt = err_count + ERR_W'(1);
            if (miss_cnt == UNLOCK_C - 4'd1) begin
              state_nxt = HUNT;
              match_nxt = '0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss_cnt + 4'd1;
            end
          end
        end
      endcase
    end
    // A clear wins over a same-cycle increment; the pulse is still reported.
    if (bus.clr_cnt) count_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      prev_vld  <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      state     <= HUNT;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      if (bus.in_valid) begin
        prev     <= bus.in_word;
        prev_vld <= 1'b1;
      end
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      state     <= state_nxt;
      err_pulse <= pulse_nxt;
      err_count <= count_nxt;
    end
  end

`ifdef LFSR_CHK_ZERO_DET_EN
  logic zero_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_flag <= 1'b0;
    else if (bus.in_valid && bus.in_word == '0) zero_flag <= 1'b1;
  end

  assign bus.zero_flag = zero_flag;
`else
  assign bus.zero_flag = 1'b0;
`endif

  assign bus.locked    = (state == LOCKED);
  assign bus.err_pulse = err_pulse;
  assign bus.err_count = err_count;
  assign bus.state     = state;

endmodule
